// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters.
// The grant is combinational from req_valid and a rotating priority pointer.
// The response (one-hot completion plus read data) is registered, one cycle after the transfer.
module ram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             ram_we,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_din,
    input  logic [DATA_WIDTH-1:0]            ram_dout
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [PtrW-1:0]       gnt_idx;
    logic [PtrW-1:0]       cand;
    logic                  gnt_any;
    logic [NUM_REQ-1:0]    gnt;
    int unsigned           scan;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    // Pick the first valid requester scanning from ptr with wrap; nothing wins during reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        scan    = 0;
        cand    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            scan = 32'(ptr_q) + off;
            // One subtraction suffices: ptr_q < NUM_REQ and off < NUM_REQ.
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            cand = PtrW'(scan);
            if (!gnt_any && !rst && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = gnt;

    // Steer the winner onto the RAM port; drive zeros when idle.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt_any) begin
            ram_we   = req_we[gnt_idx];
            ram_addr = req_addr[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            ram_din  = req_wdata[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next pointer and response contents; explicit wrap keeps ptr in range for any NUM_REQ.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = gnt;
        rsp_rdata_d = rsp_rdata_q;
        if (gnt_any) begin
            ptr_d       = (32'(gnt_idx) + 1 == NUM_REQ) ? '0 : gnt_idx + 1'b1;
            rsp_rdata_d = req_we[gnt_idx] ? '0 : ram_dout;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Mask responses while rst is high, so a response falling due in the reset cycle is dropped.
    assign rsp_valid = rst ? '0 : rsp_valid_q;
    assign rsp_rdata = rst ? '0 : rsp_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with three requesters and a behavioural RAM.
module tb_ram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    ram_port_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on rising edge.
    logic [DW-1:0] mem [0:65535];
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0]  vld;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Per-requester programs of operations, each held until accepted.
    logic          prog_we   [N][16];
    logic [AW-1:0] prog_addr [N][16];
    logic [DW-1:0] prog_wd   [N][16];
    int            pcnt [N];
    int            pidx [N];
    logic [N-1:0]  acc;

    logic [N-1:0]  s_ready;
    logic          s_we;
    logic [N-1:0]  s_rsp_valid;
    logic [DW-1:0] s_rsp_rdata;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] vld, input logic [DW-1:0] data);
        exp_t e;
        e.vld  = vld;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic add_op(input int r, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        prog_we[r][pcnt[r]]   = we;
        prog_addr[r][pcnt[r]] = a;
        prog_wd[r][pcnt[r]]   = d;
        pcnt[r]++;
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (pidx[i] < pcnt[i]) begin
                req_valid[i]           = 1'b1;
                req_we[i]              = prog_we[i][pidx[i]];
                req_addr[i*AW +: AW]   = prog_addr[i][pidx[i]];
                req_wdata[i*DW +: DW]  = prog_wd[i][pidx[i]];
            end else begin
                req_valid[i]           = 1'b0;
                req_we[i]              = 1'b0;
                req_addr[i*AW +: AW]   = '0;
                req_wdata[i*DW +: DW]  = '0;
            end
        end
    endtask

    // Snapshot outputs mid-cycle, then retire accepted ops after the edge.
    task automatic step();
        @(negedge clk);
        s_ready     = req_ready;
        s_we        = ram_we;
        s_rsp_valid = rsp_valid;
        s_rsp_rdata = rsp_rdata;
        acc         = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) pidx[i]++;
        end
        present();
    endtask

    // Monitor: every response pops the scoreboard in order.
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got valid=%b data=%h expected none",
                         rsp_valid, rsp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                chk("rsp_rdata", rsp_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        acc       = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0001] = 32'h0000_0011;
        mem[16'h0002] = 32'h0000_0022;
        mem[16'h0020] = 32'h0BAD_0020;
        for (int i = 0; i < N; i++) begin
            pcnt[i] = 0;
            pidx[i] = 0;
        end

        // Reset state
        repeat (2) begin
            step();
            chk("rst_ready", 32'(s_ready), 0);
            chk("rst_ram_we", 32'(s_we), 0);
            chk("rst_rsp_valid", 32'(s_rsp_valid), 0);
            chk("rst_rsp_rdata", s_rsp_rdata, 0);
        end
        rst = 1'b0;
        step();
        chk("post_rst_rsp_valid", 32'(s_rsp_valid), 0);
        chk("post_rst_rsp_rdata", s_rsp_rdata, 0);
        chk("post_rst_ready", 32'(s_ready), 0);

        // Single write then read by req0
        add_op(0, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        add_op(0, 1'b0, 16'h0010, 32'h0);
        push(3'b001, 32'h0);
        push(3'b001, 32'hDEAD_BEEF);
        present();
        step();
        chk("wr_ready", 32'(s_ready), 32'b001);
        chk("wr_ram_we", 32'(s_we), 1);
        step();
        chk("rd_ready", 32'(s_ready), 32'b001);
        chk("rd_ram_we", 32'(s_we), 0);
        step();

        // Contention after reset: strict alternation starting at 0, no bubbles
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            add_op(0, 1'b0, 16'h0001, 32'h0);
            add_op(1, 1'b0, 16'h0002, 32'h0);
            push(3'b001, 32'h11);
            push(3'b010, 32'h22);
        end
        present();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("cont_grant", 32'(s_ready), (k % 2 == 0) ? 32'b001 : 32'b010);
        end
        step();

        // Idle: nothing happens, ptr left at 2
        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle_ready", 32'(s_ready), 0);
            chk("idle_ram_we", 32'(s_we), 0);
            chk("idle_rsp_valid", 32'(s_rsp_valid), 0);
        end

        // ptr held at 2: req2 beats req0
        add_op(0, 1'b0, 16'h0001, 32'h0);
        add_op(2, 1'b0, 16'h0002, 32'h0);
        push(3'b100, 32'h22);
        push(3'b001, 32'h11);
        present();
        step();
        chk("hold_grant2", 32'(s_ready), 32'b100);
        step();
        chk("hold_grant0", 32'(s_ready), 32'b001);
        step();

        // Wrap: req2 alone, then all three -> 0,1,2,0
        add_op(2, 1'b0, 16'h0001, 32'h0);
        push(3'b100, 32'h11);
        present();
        step();
        chk("wrap_solo2", 32'(s_ready), 32'b100);
        add_op(0, 1'b0, 16'h0001, 32'h0);
        add_op(0, 1'b0, 16'h0001, 32'h0);
        add_op(1, 1'b0, 16'h0002, 32'h0);
        add_op(2, 1'b0, 16'h0010, 32'h0);
        push(3'b001, 32'h11);
        push(3'b010, 32'h22);
        push(3'b100, 32'hDEAD_BEEF);
        push(3'b001, 32'h11);
        present();
        step();
        chk("wrap_g0", 32'(s_ready), 32'b001);
        step();
        chk("wrap_g1", 32'(s_ready), 32'b010);
        step();
        chk("wrap_g2", 32'(s_ready), 32'b100);
        step();
        chk("wrap_g0b", 32'(s_ready), 32'b001);
        step();

        // Reset mid-stream: response due in the reset cycle is dropped, write ignored
        add_op(0, 1'b0, 16'h0001, 32'h0);
        present();
        step();
        chk("pre_rst_grant", 32'(s_ready), 32'b001);
        rst = 1'b1;
        add_op(1, 1'b1, 16'h0020, 32'h5);
        present();
        step();
        chk("midrst_ready", 32'(s_ready), 0);
        chk("midrst_ram_we", 32'(s_we), 0);
        chk("midrst_rsp_valid", 32'(s_rsp_valid), 0);
        rst = 1'b0;
        pidx[1] = pcnt[1];
        present();
        step();
        chk("after_rst_rsp_valid", 32'(s_rsp_valid), 0);
        chk("after_rst_ready", 32'(s_ready), 0);
        add_op(0, 1'b0, 16'h0020, 32'h0);
        add_op(1, 1'b0, 16'h0002, 32'h0);
        push(3'b001, 32'h0BAD_0020);
        push(3'b010, 32'h22);
        present();
        step();
        chk("ptr_reset_g0", 32'(s_ready), 32'b001);
        step();
        chk("ptr_reset_g1", 32'(s_ready), 32'b010);
        step();

        // Move ptr from 2 to 0
        add_op(2, 1'b0, 16'h0002, 32'h0);
        push(3'b100, 32'h22);
        present();
        step();
        chk("pre_race_g2", 32'(s_ready), 32'b100);

        // Write/read race on 0x00FF
        add_op(0, 1'b1, 16'h00FF, 32'hA5A5_A5A5);
        add_op(1, 1'b0, 16'h00FF, 32'h0);
        push(3'b001, 32'h0);
        push(3'b010, 32'hA5A5_A5A5);
        present();
        step();
        chk("race_g0", 32'(s_ready), 32'b001);
        chk("race_we", 32'(s_we), 1);
        step();
        chk("race_g1", 32'(s_ready), 32'b010);
        chk("race_rd_we", 32'(s_we), 0);
        step();
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
